ef_tmr32_dtg: RTL
=================

# ef_tmr32_dtg

Dead-time generator and fault gate that sits directly downstream of the EF_TMR32 timer's `pwm0` output. It turns the single PWM waveform into a complementary high-side/low-side pair with programmable, non-overlapping dead time. It also conditions a raw external fault pin into the filtered, latched `pwm_fault` level that feeds back into the timer. While a fault is latched, both gate outputs are forced to their inactive levels.

## Interface
- `DT_W`, 8: width of dead-time counts; max dead time 2^DT_W−1 cycles
- `FLT_FILT`, 4: consecutive synchronized-high cycles required to accept a fault (≥1)
- `H_ACT_LOW`, 0: 1 = `pwm_h` active-low
- `L_ACT_LOW`, 0: 1 = `pwm_l` active-low

Ports:
- `clk_i`  in  1  block clock; one clock domain
- `rst_i`  in  1  reset, synchronous, active-high
- `en`  in  1  generator enable
- `pwm_in`  in  1  PWM from timer, synchronous to `clk_i`
- `dt_rise`  in  DT_W  dead time before `pwm_h` turns on
- `dt_fall`  in  DT_W  dead time before `pwm_l` turns on
- `fault_in`  in  1  raw asynchronous fault pin, active-high
- `fault_clr`  in  1  one-cycle request to clear the fault latch
- `pwm_h`  out  1  high-side gate, registered
- `pwm_l`  out  1  low-side gate, registered
- `fault_o`  out  1  latched fault; drives timer `pwm_fault`
- `dt_busy`  out  1  high while in a dead-time state

## Operation
- **States:** OFF, L_ON, DT_TO_H, H_ON, DT_TO_L, FAULT. One 2^DT_W-range down-counter `cnt`.
- **Output decode** (logical "on" before polarity):
  - `pwm_h` on only in H_ON.
  - `pwm_l` on only in L_ON.
  - All other states: both off.
  - Outputs are flops loaded from the next-state decode, then XORed with the polarity parameters.
- **OFF:** when `en`=1 → L_ON.
- **L_ON:**
  - `pwm_in`=1 → DT_TO_H with `cnt`←`dt_rise`.
  - If `dt_rise`=0 → H_ON directly.
- **DT_TO_H:**
  - `pwm_in`=0 → L_ON. Aborted pulse; high side never driven.
  - Else if `cnt`≤1 → H_ON.
  - Else `cnt`−1.
- **H_ON / DT_TO_L:** symmetric, using `dt_fall` and `pwm_in`=0.
- **Dead-time sampling:** `dt_rise`/`dt_fall` are sampled only on entry to a dead-time state. Changes mid-interval take effect at the next transition.
- **`en`=0:** any non-FAULT state → OFF on the next edge. FAULT is unaffected by `en`.
- **Fault path:**
  - `fault_in` passes through a 2-flop synchronizer, then a saturating filter counter.
  - The counter increments while the synchronized value is 1 and clears when it is 0.
  - The filtered fault is asserted when the counter reaches `FLT_FILT`.
  - Filtered fault sets `fault_o` and forces FAULT from any state (including OFF) on the same edge.
- **Fault clear:**
  - `fault_clr` clears `fault_o` only when the filtered fault is deasserted; otherwise it is ignored.
  - Set has priority over clear when both occur in the same cycle.
  - On clear, FAULT → OFF. Normal re-entry follows through L_ON, so the low side always starts first.
- **`dt_busy`:** 1 in DT_TO_H and DT_TO_L.

## Timing
- **Reset:**
  - Synchronous: state OFF, `cnt`=0, filter and synchronizer cleared.
  - `fault_o`=0, `dt_busy`=0.
  - `pwm_h`=`H_ACT_LOW`, `pwm_l`=`L_ACT_LOW` (inactive levels).
  - Reset mid-dead-time or mid-fault aborts immediately.
- **Rising PWM:** `pwm_in` sampled 1 at edge k in L_ON:
  - `pwm_l` goes inactive after edge k.
  - `pwm_h` goes active after edge k+`dt_rise`.
  - Both are inactive for exactly `dt_rise` cycles.
  - `dt_rise`=0: swap on the same edge, zero gap.
- **Falling PWM:** same timing as rising, using `dt_fall`.
- **Overlap:** `pwm_h` and `pwm_l` are never both logically on in any cycle.
- **Fault latency:** `fault_in` high from cycle j → `fault_o`=1 and outputs inactive after edge j+2+`FLT_FILT`.
- **Glitch rejection:** a glitch shorter than `FLT_FILT` cycles after synchronization has no effect.
- **Clear latency:** `fault_clr` accepted at edge k → `fault_o`=0 and state OFF after edge k. Earliest `pwm_l` active is after edge k+1 (with `en`=1).

## Test plan
- **Basic dead time:** `en`=1, `dt_rise`=3, `dt_fall`=5, `pwm_in` period 40 with 50% duty → each rise gives exactly 3 both-off cycles, each fall gives exactly 5; never any overlap.
- **Zero dead time:** `dt_rise`=`dt_fall`=0 → `pwm_h` tracks `pwm_in` delayed 1 cycle; `pwm_l` is its exact complement.
- **Short pulse:** `dt_rise`=8, 4-cycle `pwm_in` pulse → `pwm_h` never asserts; `pwm_l` returns active 1 cycle after `pwm_in` falls; `dt_busy` high for 4 cycles.
- **Fault filter:** `FLT_FILT`=4:
  - 3-cycle `fault_in` glitch → `fault_o` stays 0.
  - Sustained `fault_in` from cycle 100 → `fault_o`=1 and both outputs inactive after edge 106.
- **Fault clear:**
  - `fault_clr` while `fault_in` is still high → ignored.
  - After `fault_in` low for ≥3 cycles, `fault_clr` → `fault_o`=0, then L_ON.
- **Polarity and reset:** `H_ACT_LOW`=1, `L_ACT_LOW`=1:
  - `rst_i` asserted mid-DT_TO_H → both outputs =1 after the next edge.
  - `fault_o`=0, `dt_busy`=0.

Source files
------------

// File: rtl/ef_tmr32_dtg_if.sv
// Signal bundle between the EF_TMR32 PWM/fault logic and the dead-time generator.
// The timer side uses master; the generator uses slave.
interface ef_tmr32_dtg_if #(
  parameter int DT_W = 8
);
  logic            en;
  logic            pwm_in;
  logic [DT_W-1:0] dt_rise;
  logic [DT_W-1:0] dt_fall;
  logic            fault_in;
  logic            fault_clr;
  logic            pwm_h;
  logic            pwm_l;
  logic            fault_o;
  logic            dt_busy;

  modport master (
    output en, pwm_in, dt_rise, dt_fall, fault_in, fault_clr,
    input  pwm_h, pwm_l, fault_o, dt_busy
  );

  modport slave (
    input  en, pwm_in, dt_rise, dt_fall, fault_in, fault_clr,
    output pwm_h, pwm_l, fault_o, dt_busy
  );
endinterface

// File: rtl/ef_tmr32_dtg.sv
// Complementary high/low gate generator with dead time and a filtered, latched fault.
// The bus interface DT_W must match this module's DT_W.
module ef_tmr32_dtg #(
  parameter int DT_W      = 8,
  parameter int FLT_FILT  = 4,
  parameter bit H_ACT_LOW = 1'b0,
  parameter bit L_ACT_LOW = 1'b0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  ef_tmr32_dtg_if.slave     bus
);

  localparam int              FW       = $clog2(FLT_FILT + 1);
  localparam logic [FW-1:0]   FLT_MAX  = FW'(FLT_FILT);
  localparam logic [FW-1:0]   FLT_ONE  = FW'(1'b1);
  localparam logic [FW-1:0]   FLT_ZERO = {FW{1'b0}};
  localparam logic [DT_W-1:0] CNT_ZERO = {DT_W{1'b0}};
  localparam logic [DT_W-1:0] CNT_ONE  = DT_W'(1'b1);

  typedef enum logic [2:0] {
    ST_OFF     = 3'd0,
    ST_L_ON    = 3'd1,
    ST_DT_TO_H = 3'd2,
    ST_H_ON    = 3'd3,
    ST_DT_TO_L = 3'd4,
    ST_FAULT   = 3'd5
  } state_t;

  state_t          state_r;
  state_t          state_nxt_s;
  logic [DT_W-1:0] cnt_r;
  logic [DT_W-1:0] cnt_nxt_s;
  logic            fault_r;
  logic            fault_nxt_s;
  logic [1:0]      sync_r;
  logic [FW-1:0]   flt_cnt_r;
  logic            flt_act_s;
  logic            h_on_r;
  logic            l_on_r;
  logic            busy_r;

  assign flt_act_s = (flt_cnt_r == FLT_MAX);

  // Fault pin synchronizer and saturating run-length filter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_r    <= 2'b00;
      flt_cnt_r <= FLT_ZERO;
    end else begin
      sync_r <= {sync_r[0], bus.fault_in};
      if (!sync_r[1]) begin
        flt_cnt_r <= FLT_ZERO;
      end else if (flt_cnt_r != FLT_MAX) begin
        flt_cnt_r <= flt_cnt_r + FLT_ONE;
      end else begin
        flt_cnt_r <= flt_cnt_r;
      end
    end
  end

  // Next-state decode: fault set beats clear, clear beats enable, enable beats PWM tracking.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    fault_nxt_s = fault_r;
    if (flt_act_s) begin
      state_nxt_s = ST_FAULT;
      fault_nxt_s = 1'b1;
    end else if (state_r == ST_FAULT) begin
      if (bus.fault_clr) begin
        state_nxt_s = ST_OFF;
        fault_nxt_s = 1'b0;
      end else begin
        state_nxt_s = ST_FAULT;
      end
    end else if (!bus.en) begin
      state_nxt_s = ST_OFF;
    end else begin
      case (state_r)
        ST_OFF: state_nxt_s = ST_L_ON;
        ST_L_ON: begin
          if (!bus.pwm_in) begin
            state_nxt_s = ST_L_ON;
          end else if (bus.dt_rise == CNT_ZERO) begin
            state_nxt_s = ST_H_ON;
          end else begin
            state_nxt_s = ST_DT_TO_H;
            cnt_nxt_s   = bus.dt_rise;
          end
        end
        // A PWM reversal during dead time returns straight to the side still safe to drive.
        ST_DT_TO_H: begin
          if (!bus.pwm_in) begin
            state_nxt_s = ST_L_ON;
          end else if (cnt_r <= CNT_ONE) begin
            state_nxt_s = ST_H_ON;
          end else begin
            cnt_nxt_s = cnt_r - CNT_ONE;
          end
        end
        ST_H_ON: begin
          if (bus.pwm_in) begin
            state_nxt_s = ST_H_ON;
          end else if (bus.dt_fall == CNT_ZERO) begin
            state_nxt_s = ST_L_ON;
          end else begin
            state_nxt_s = ST_DT_TO_L;
            cnt_nxt_s   = bus.dt_fall;
          end
        end
        ST_DT_TO_L: begin
          if (bus.pwm_in) begin
            state_nxt_s = ST_H_ON;
          end else if (cnt_r <= CNT_ONE) begin
            state_nxt_s = ST_L_ON;
          end else begin
            cnt_nxt_s = cnt_r - CNT_ONE;
          end
        end
        default: state_nxt_s = ST_OFF;
      endcase
    end
  end

  // State register with gate flops loaded from the next-state decode.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r <= ST_OFF;
      cnt_r   <= CNT_ZERO;
      fault_r <= 1'b0;
      h_on_r  <= 1'b0;
      l_on_r  <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      fault_r <= fault_nxt_s;
      h_on_r  <= (state_nxt_s == ST_H_ON);
      l_on_r  <= (state_nxt_s == ST_L_ON);
      busy_r  <= (state_nxt_s == ST_DT_TO_H) || (state_nxt_s == ST_DT_TO_L);
    end
  end

  assign bus.pwm_h   = h_on_r ^ H_ACT_LOW;
  assign bus.pwm_l   = l_on_r ^ L_ACT_LOW;
  assign bus.fault_o = fault_r;
  assign bus.dt_busy = busy_r;

endmodule
